// File: rtl/menu_cursor_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : menu_cursor_ctrl
// Description : Menu cursor sequencer for the VGA highlight box. Turns button
//               presses into a frame-aligned cursor index and box address.
// Revision    : 1.0 - initial release
// ============================================================================
module menu_cursor_ctrl #(
    parameter int          NUM_ITEMS      = 4,
    parameter logic [18:0] ITEM0_ADDR     = 19'd96320,
    parameter logic [18:0] ITEM_STRIDE    = 19'd25600,
    parameter int          BLINK_FRAMES   = 15,
    parameter int          CONFIRM_FRAMES = 8
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic        frame_start,
    input  logic        menu_active,
    input  logic        btn_up,
    input  logic        btn_down,
    input  logic        btn_select,
    output logic [18:0] box_startaddr,
    output logic        highlight_en,
    output logic [1:0]  cur_index,
    output logic        sel_valid,
    output logic [1:0]  sel_index
);

    localparam logic [1:0] c_st_idle    = 2'd0;
    localparam logic [1:0] c_st_run     = 2'd1;
    localparam logic [1:0] c_st_confirm = 2'd2;
    localparam logic [1:0] c_st_done    = 2'd3;

    localparam logic [1:0] c_pend_none = 2'd0;
    localparam logic [1:0] c_pend_up   = 2'd1;
    localparam logic [1:0] c_pend_down = 2'd2;

    localparam int c_cnt_max = (BLINK_FRAMES > CONFIRM_FRAMES) ? BLINK_FRAMES : CONFIRM_FRAMES;
    localparam int c_cnt_w   = $clog2(c_cnt_max + 1);

    localparam logic [1:0]         c_last_idx    = 2'(NUM_ITEMS - 1);
    localparam logic [c_cnt_w-1:0] c_blink_last  = c_cnt_w'(BLINK_FRAMES - 1);
    localparam logic [c_cnt_w-1:0] c_confirm_last = c_cnt_w'(CONFIRM_FRAMES - 1);

    // Button bit order: [0]=up, [1]=down, [2]=select
    logic [2:0] r_btn_s1, r_btn_s2, r_btn_s3, r_press;

    logic [1:0]         r_state;
    logic [1:0]         r_pend;
    logic [1:0]         r_cur_index;
    logic [1:0]         r_cand_index;
    logic [1:0]         r_sel_index;
    logic [18:0]        r_box_addr;
    logic               r_highlight;
    logic               r_sel_valid;
    logic [c_cnt_w-1:0] r_frame_cnt;

    logic        w_up, w_down, w_sel;
    logic [1:0]  w_step_idx;
    logic [1:0]  w_next_idx;
    logic [1:0]  w_pend_next;
    logic [18:0] w_step_addr;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_btn_s1 <= 3'b000;
            r_btn_s2 <= 3'b000;
            r_btn_s3 <= 3'b000;
            r_press  <= 3'b000;
        end else begin
            r_btn_s1 <= {btn_select, btn_down, btn_up};
            r_btn_s2 <= r_btn_s1;
            r_btn_s3 <= r_btn_s2;
            r_press  <= r_btn_s2 & ~r_btn_s3;
        end
    end

    // Simultaneous up and down cancel each other and leave the slot alone
    assign w_up   = r_press[0] & ~r_press[1];
    assign w_down = r_press[1] & ~r_press[0];
    assign w_sel  = r_press[2];

    always_comb begin
        w_step_idx = r_cur_index;
        if (r_pend == c_pend_down) begin
            w_step_idx = (r_cur_index == c_last_idx) ? 2'd0 : r_cur_index + 2'd1;
        end else if (r_pend == c_pend_up) begin
            w_step_idx = (r_cur_index == 2'd0) ? c_last_idx : r_cur_index - 2'd1;
        end
    end

    assign w_next_idx  = frame_start ? w_step_idx : r_cur_index;
    assign w_step_addr = ITEM0_ADDR + 19'(w_step_idx) * ITEM_STRIDE;

    always_comb begin
        w_pend_next = r_pend;
        if (frame_start) begin
            w_pend_next = c_pend_none;
        end
        if (w_up) begin
            w_pend_next = c_pend_up;
        end else if (w_down) begin
            w_pend_next = c_pend_down;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state      <= c_st_idle;
            r_pend       <= c_pend_none;
            r_cur_index  <= 2'd0;
            r_cand_index <= 2'd0;
            r_sel_index  <= 2'd0;
            r_box_addr   <= ITEM0_ADDR;
            r_highlight  <= 1'b0;
            r_sel_valid  <= 1'b0;
            r_frame_cnt  <= '0;
        end else begin
            r_sel_valid <= 1'b0;
            case (r_state)
                c_st_idle: begin
                    r_highlight <= 1'b0;
                    if (menu_active) begin
                        r_state     <= c_st_run;
                        r_pend      <= c_pend_none;
                        r_frame_cnt <= '0;
                        r_highlight <= 1'b1;
                    end
                end
                c_st_run: begin
                    if (!menu_active) begin
                        r_state     <= c_st_idle;
                        r_pend      <= c_pend_none;
                        r_highlight <= 1'b0;
                    end else begin
                        if (frame_start) begin
                            r_cur_index <= w_step_idx;
                            r_box_addr  <= w_step_addr;
                            if (r_frame_cnt == c_blink_last) begin
                                r_frame_cnt <= '0;
                                r_highlight <= ~r_highlight;
                            end else begin
                                r_frame_cnt <= r_frame_cnt + 1'b1;
                            end
                        end
                        // The candidate sees this frame's move before it is latched
                        if (w_sel) begin
                            r_state      <= c_st_confirm;
                            r_pend       <= c_pend_none;
                            r_frame_cnt  <= '0;
                            r_cand_index <= w_next_idx;
                        end else begin
                            r_pend <= w_pend_next;
                        end
                    end
                end
                c_st_confirm: begin
                    if (!menu_active) begin
                        r_state     <= c_st_idle;
                        r_highlight <= 1'b0;
                    end else if (frame_start) begin
                        if (r_frame_cnt == c_confirm_last) begin
                            r_state     <= c_st_done;
                            r_frame_cnt <= '0;
                            r_sel_valid <= 1'b1;
                            r_sel_index <= r_cand_index;
                            r_highlight <= 1'b1;
                        end else begin
                            r_frame_cnt <= r_frame_cnt + 1'b1;
                            r_highlight <= ~r_highlight;
                        end
                    end
                end
                default: begin
                    r_highlight <= 1'b1;
                    if (!menu_active) begin
                        r_state     <= c_st_idle;
                        r_highlight <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign box_startaddr = r_box_addr;
    assign highlight_en  = r_highlight;
    assign cur_index     = r_cur_index;
    assign sel_valid     = r_sel_valid;
    assign sel_index     = r_sel_index;

endmodule
`default_nettype wire

// File: tb/tb_menu_cursor_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_menu_cursor_ctrl
// Description : Directed self-checking bench for menu_cursor_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_menu_cursor_ctrl;

    logic        clock = 1'b0;
    logic        resetn = 1'b0;
    logic        frame_start = 1'b0;
    logic        menu_active = 1'b0;
    logic        btn_up = 1'b0;
    logic        btn_down = 1'b0;
    logic        btn_select = 1'b0;
    logic [18:0] box_startaddr;
    logic        highlight_en;
    logic [1:0]  cur_index;
    logic        sel_valid;
    logic [1:0]  sel_index;

    int total = 0;
    int bad = 0;
    int sv_count = 0;

    menu_cursor_ctrl dut (
        .clock         (clock),
        .resetn        (resetn),
        .frame_start   (frame_start),
        .menu_active   (menu_active),
        .btn_up        (btn_up),
        .btn_down      (btn_down),
        .btn_select    (btn_select),
        .box_startaddr (box_startaddr),
        .highlight_en  (highlight_en),
        .cur_index     (cur_index),
        .sel_valid     (sel_valid),
        .sel_index     (sel_index)
    );

    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (sel_valid === 1'b1) sv_count++;
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic do_start();
        resetn = 1'b0; menu_active = 1'b0; frame_start = 1'b0;
        btn_up = 1'b0; btn_down = 1'b0; btn_select = 1'b0;
        cyc(2);
        resetn = 1'b1;
        cyc(1);
        menu_active = 1'b1;
        cyc(2);
    endtask

    task automatic press(input logic u, input logic d, input logic s);
        btn_up = u; btn_down = d; btn_select = s;
        cyc(1);
        btn_up = 1'b0; btn_down = 1'b0; btn_select = 1'b0;
        cyc(4);
    endtask

    task automatic frame();
        cyc(1);
        frame_start = 1'b1;
        cyc(1);
        frame_start = 1'b0;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        cyc(2);
        total++; if (cur_index !== 2'd0) begin bad++; $display("FAIL reset_idx: got %0d want 0", cur_index); end
        total++; if (box_startaddr !== 19'd96320) begin bad++; $display("FAIL reset_addr: got %0d want 96320", box_startaddr); end
        total++; if (highlight_en !== 1'b0) begin bad++; $display("FAIL reset_hl: got %b want 0", highlight_en); end
        total++; if (sel_valid !== 1'b0 || sel_index !== 2'd0) begin bad++; $display("FAIL reset_sel: got %b/%0d want 0/0", sel_valid, sel_index); end
        do_start();
        total++; if (highlight_en !== 1'b1) begin bad++; $display("FAIL run_entry_hl: got %b want 1", highlight_en); end
        total++; if (box_startaddr !== 19'd96320 || cur_index !== 2'd0) begin bad++; $display("FAIL run_entry_pos: got %0d/%0d want 96320/0", box_startaddr, cur_index); end
    endtask

    task automatic test_down();
        do_start();
        press(1'b0, 1'b1, 1'b0);
        total++; if (cur_index !== 2'd0 || box_startaddr !== 19'd96320) begin bad++; $display("FAIL down_early: got %0d/%0d want 0/96320", cur_index, box_startaddr); end
        frame();
        total++; if (cur_index !== 2'd1 || box_startaddr !== 19'd121920) begin bad++; $display("FAIL down_step: got %0d/%0d want 1/121920", cur_index, box_startaddr); end
    endtask

    task automatic test_up_wrap();
        do_start();
        press(1'b1, 1'b0, 1'b0);
        frame();
        total++; if (cur_index !== 2'd3 || box_startaddr !== 19'd173120) begin bad++; $display("FAIL up_wrap: got %0d/%0d want 3/173120", cur_index, box_startaddr); end
        press(1'b1, 1'b1, 1'b0);
        frame();
        total++; if (cur_index !== 2'd3 || box_startaddr !== 19'd173120) begin bad++; $display("FAIL up_down_cancel: got %0d/%0d want 3/173120", cur_index, box_startaddr); end
        press(1'b0, 1'b1, 1'b0);
        frame();
        total++; if (cur_index !== 2'd0 || box_startaddr !== 19'd96320) begin bad++; $display("FAIL down_wrap: got %0d/%0d want 0/96320", cur_index, box_startaddr); end
    endtask

    task automatic test_single_step();
        do_start();
        press(1'b0, 1'b1, 1'b0);
        press(1'b0, 1'b1, 1'b0);
        frame();
        total++; if (cur_index !== 2'd1) begin bad++; $display("FAIL double_press: got %0d want 1", cur_index); end
        frame();
        total++; if (cur_index !== 2'd1) begin bad++; $display("FAIL slot_cleared: got %0d want 1", cur_index); end
        btn_down = 1'b1;
        cyc(4);
        frame(); frame(); frame();
        btn_down = 1'b0;
        cyc(3);
        frame();
        total++; if (cur_index !== 2'd2 || box_startaddr !== 19'd147520) begin bad++; $display("FAIL held_button: got %0d/%0d want 2/147520", cur_index, box_startaddr); end
    endtask

    task automatic test_back_to_back();
        do_start();
        press(1'b0, 1'b1, 1'b0);
        btn_up = 1'b1;
        cyc(1);
        btn_up = 1'b0;
        cyc(2);
        frame_start = 1'b1;
        cyc(1);
        frame_start = 1'b0;
        total++; if (cur_index !== 2'd1) begin bad++; $display("FAIL frame_press_old: got %0d want 1", cur_index); end
        frame();
        total++; if (cur_index !== 2'd0) begin bad++; $display("FAIL frame_press_new: got %0d want 0", cur_index); end
    endtask

    task automatic test_select();
        int base;
        logic exp_hl;
        do_start();
        press(1'b0, 1'b1, 1'b0);
        frame();
        press(1'b0, 1'b1, 1'b0);
        frame();
        total++; if (cur_index !== 2'd2) begin bad++; $display("FAIL sel_setup: got %0d want 2", cur_index); end
        base = sv_count;
        press(1'b0, 1'b0, 1'b1);
        exp_hl = 1'b1;
        total++; if (highlight_en !== exp_hl) begin bad++; $display("FAIL confirm_entry_hl: got %b want 1", highlight_en); end
        for (int k = 1; k <= 7; k++) begin
            frame();
            exp_hl = ~exp_hl;
            total++; if (highlight_en !== exp_hl || sel_valid !== 1'b0) begin bad++; $display("FAIL confirm_blink%0d: got hl=%b sv=%b want hl=%b sv=0", k, highlight_en, sel_valid, exp_hl); end
        end
        frame();
        total++; if (sel_valid !== 1'b1 || sel_index !== 2'd2) begin bad++; $display("FAIL sel_report: got sv=%b idx=%0d want 1/2", sel_valid, sel_index); end
        total++; if (highlight_en !== 1'b1) begin bad++; $display("FAIL done_hl: got %b want 1", highlight_en); end
        cyc(1);
        total++; if (sel_valid !== 1'b0) begin bad++; $display("FAIL sel_one_cycle: got %b want 0", sel_valid); end
        frame(); frame();
        total++; if (sv_count - base !== 1 || highlight_en !== 1'b1) begin bad++; $display("FAIL done_steady: got pulses=%0d hl=%b want 1/1", sv_count - base, highlight_en); end
        menu_active = 1'b0;
        cyc(1);
        total++; if (highlight_en !== 1'b0 || sel_index !== 2'd2) begin bad++; $display("FAIL done_to_idle: got hl=%b idx=%0d want 0/2", highlight_en, sel_index); end
        press(1'b0, 1'b1, 1'b0);
        frame();
        total++; if (cur_index !== 2'd2 || highlight_en !== 1'b0) begin bad++; $display("FAIL idle_ignore: got %0d/%b want 2/0", cur_index, highlight_en); end
    endtask

    task automatic test_abort();
        int base;
        do_start();
        press(1'b0, 1'b1, 1'b0);
        frame();
        base = sv_count;
        press(1'b0, 1'b0, 1'b1);
        frame(); frame(); frame();
        #2 resetn = 1'b0;
        #1;
        total++; if (cur_index !== 2'd0 || box_startaddr !== 19'd96320 || highlight_en !== 1'b0 || sel_valid !== 1'b0 || sel_index !== 2'd0) begin
            bad++; $display("FAIL async_reset: got idx=%0d addr=%0d hl=%b sv=%b sel=%0d want 0/96320/0/0/0", cur_index, box_startaddr, highlight_en, sel_valid, sel_index);
        end
        cyc(1);
        resetn = 1'b1;
        for (int k = 0; k < 10; k++) frame();
        total++; if (sv_count !== base) begin bad++; $display("FAIL reset_no_sel: got %0d pulses want 0", sv_count - base); end

        do_start();
        press(1'b0, 1'b1, 1'b0);
        frame();
        base = sv_count;
        press(1'b0, 1'b0, 1'b1);
        frame(); frame(); frame();
        menu_active = 1'b0;
        cyc(1);
        total++; if (highlight_en !== 1'b0 || cur_index !== 2'd1 || box_startaddr !== 19'd121920) begin
            bad++; $display("FAIL deassert_idle: got hl=%b idx=%0d addr=%0d want 0/1/121920", highlight_en, cur_index, box_startaddr);
        end
        for (int k = 0; k < 10; k++) frame();
        total++; if (sv_count !== base || highlight_en !== 1'b0) begin bad++; $display("FAIL deassert_no_sel: got pulses=%0d hl=%b want 0/0", sv_count - base, highlight_en); end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_down();
        test_up_wrap();
        test_single_step();
        test_back_to_back();
        test_select();
        test_abort();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
